fifo_data_sequencer: RTL
========================

FIFO_DATA_SEQUENCER -- requirements
Module: fifo_data_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample word width, 1..32.
REQ-002 SHALL have parameter CNT_W, default 16, width of the delivered-word counter, 1..32.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports address input 2, read input 1, write input 1, writedata input 32: CPU register slave.
REQ-006 SHALL have port readdata  output  32  registered read data.
REQ-007 SHALL have ports fifo_q input DATA_W, fifo_empty input 1, fifo_rdreq output 1: normal-mode (non-show-ahead) sample FIFO read side.
REQ-008 SHALL have port irq  output  1  underflow interrupt (see Configuration).

Function
REQ-009 SHALL implement states IDLE, FETCH, LATCH, HOLD, FLUSH.
REQ-010 IDLE -> FETCH when enable=1 and fifo_empty=0; otherwise stay IDLE.
REQ-011 FETCH SHALL assert fifo_rdreq for exactly one cycle, then -> LATCH.
REQ-012 LATCH SHALL capture fifo_q into hold register, set valid=1, -> HOLD.
REQ-013 HOLD SHALL remain until a read of address 0, then clear valid, increment count, -> IDLE (next fetch starts the following cycle).
REQ-014 fifo_rdreq SHALL never be asserted while fifo_empty=1.
REQ-015 Read latency SHALL be 1 cycle; readdata holds its value when read=0.
REQ-016 Address 0 read: readdata = zero-extended hold when valid=1; else readdata=0 and underflow sticky set.
REQ-017 Address 1 read (STATUS): bit0 valid, bit1 fifo_empty, bit2 underflow, bit3 enable, bit4 flush_busy, others 0.
REQ-018 Address 2 read (CONTROL): bit0 enable, others 0.
REQ-019 Address 3 read: zero-extended count (wraps modulo 2^CNT_W).
REQ-020 Write address 1 with bit2=1 SHALL clear underflow; other bits ignored.
REQ-021 Write address 2: bit0 -> enable; bit1=1 SHALL enter FLUSH from any state after the current cycle.
REQ-022 FLUSH SHALL clear valid, assert fifo_rdreq every cycle fifo_empty=0, discard data, -> IDLE on first cycle fifo_empty=1; flush_busy=1 throughout.
REQ-023 Write address 3 SHALL clear count; simultaneous increment loses to clear.
REQ-024 Clearing enable during FETCH/LATCH SHALL complete the capture (no word lost); no new fetch starts while enable=0.
REQ-025 Read of address 0 during FETCH or LATCH SHALL be treated as underflow (valid still 0).
REQ-026 Simultaneous read and write in one cycle: write takes effect, read returns pre-write state.

Reset
REQ-027 Reset SHALL force state IDLE, readdata=0, fifo_rdreq=0, irq=0, hold=0, valid=0, enable=0, underflow=0, count=0, immediately and regardless of clk.
REQ-028 Reset mid-FETCH SHALL drop fifo_rdreq in the same cycle; the captured word is abandoned.

Configuration
REQ-029 Macro FIFO_SEQ_UNDERFLOW_IRQ_EN defined: irq SHALL equal the underflow sticky bit (level, cleared per REQ-020).
REQ-030 Macro undefined: irq SHALL be constant 0; underflow status bit still functions.

Verification
REQ-031 Reset, enable=1, FIFO holds 0x1234 -> rdreq pulse 1 cycle, valid=1 two cycles later, addr0 read returns 0x00001234, count=1.
REQ-032 Empty FIFO, enable=1, addr0 read -> readdata 0, STATUS=0x0000000E; with macro irq=1; write addr1 0x4 -> irq=0, STATUS bit2=0.
REQ-033 FIFO holds 5 words, valid=1, write addr2 0x3 -> 5 rdreq cycles total, valid=0, flush_busy high until fifo_empty, count unchanged.
REQ-034 count at 0xFFFF, one delivered read -> count=0x0000; write addr3 same cycle as delivery -> count=0.
REQ-035 Reset asserted during FETCH -> fifo_rdreq=0 and readdata=0 without clock edge; after release no rdreq until enable rewritten.

Source files
------------

// File: rtl/fifo_data_sequencer_if.sv
// Bus bundle for fifo_data_sequencer: the CPU register port and the sample-FIFO read side.
// master = environment (CPU + FIFO), slave = the sequencer.
interface fifo_data_sequencer_if #(
  parameter int DATA_W = 16
);
  logic [1:0]        address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] fifo_q;
  logic              fifo_empty;
  logic              fifo_rdreq;
  logic              irq;

  modport master (
    output address, read, write, writedata, fifo_q, fifo_empty,
    input  readdata, fifo_rdreq, irq
  );

  modport slave (
    input  address, read, write, writedata, fifo_q, fifo_empty,
    output readdata, fifo_rdreq, irq
  );
endinterface

// File: rtl/fifo_data_sequencer.sv
// Pulls words one at a time from a normal-mode FIFO and presents them to a CPU register port.
// Optional macro FIFO_SEQ_UNDERFLOW_IRQ_EN drives irq from the underflow sticky bit.
module fifo_data_sequencer #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  fifo_data_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LATCH = 3'd2,
    S_HOLD  = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_hold;
  logic              r_valid;
  logic              r_enable;
  logic              r_underflow;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_readdata;

  logic              w_rdreq;
  logic              w_flush_busy;
  logic              w_rd0;
  logic              w_wr_status;
  logic              w_wr_ctrl;
  logic              w_wr_count;
  logic              w_flush_req;
  logic              w_deliver;
  logic              w_underflow_evt;
  logic [31:0]       w_rd_mux;
  logic              w_unused;

  assign w_rd0           = bus.read  && (bus.address == 2'd0);
  assign w_wr_status     = bus.write && (bus.address == 2'd1);
  assign w_wr_ctrl       = bus.write && (bus.address == 2'd2);
  assign w_wr_count      = bus.write && (bus.address == 2'd3);
  assign w_flush_req     = w_wr_ctrl && bus.writedata[1];
  // valid is only ever set while holding, so a read of address 0 in FETCH/LATCH is an underflow
  assign w_deliver       = w_rd0 && r_valid;
  assign w_underflow_evt = w_rd0 && !r_valid;
  assign w_unused        = &{1'b0, bus.writedata[31:3]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (r_enable && !bus.fifo_empty) w_state_next = S_FETCH;
      S_FETCH: w_state_next = S_LATCH;
      S_LATCH: w_state_next = S_HOLD;
      S_HOLD:  if (w_rd0) w_state_next = S_IDLE;
      S_FLUSH: if (bus.fifo_empty) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (w_flush_req) begin
      w_state_next = S_FLUSH;
    end
  end

  // rdreq is gated by fifo_empty so it can never request from an empty FIFO
  always_comb begin
    w_rdreq      = 1'b0;
    w_flush_busy = 1'b0;
    case (r_state)
      S_FETCH: w_rdreq = !bus.fifo_empty;
      S_FLUSH: begin
        w_rdreq      = !bus.fifo_empty;
        w_flush_busy = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      2'd0:    w_rd_mux = r_valid ? 32'(r_hold) : 32'd0;
      2'd1:    w_rd_mux = {27'd0, w_flush_busy, r_enable, r_underflow, bus.fifo_empty, r_valid};
      2'd2:    w_rd_mux = {31'd0, r_enable};
      default: w_rd_mux = 32'(r_count);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold      <= '0;
      r_valid     <= 1'b0;
      r_enable    <= 1'b0;
      r_underflow <= 1'b0;
      r_count     <= '0;
      r_readdata  <= '0;
    end else begin
      if (r_state == S_LATCH) begin
        r_hold <= bus.fifo_q;
      end
      if (w_flush_req) begin
        r_valid <= 1'b0;
      end else if (r_state == S_LATCH) begin
        r_valid <= 1'b1;
      end else if (w_deliver) begin
        r_valid <= 1'b0;
      end
      if (w_wr_ctrl) begin
        r_enable <= bus.writedata[0];
      end
      // the CPU clear wins over an underflow seen in the same cycle
      if (w_wr_status && bus.writedata[2]) begin
        r_underflow <= 1'b0;
      end else if (w_underflow_evt) begin
        r_underflow <= 1'b1;
      end
      if (w_wr_count) begin
        r_count <= '0;
      end else if (w_deliver) begin
        r_count <= r_count + CNT_W'(1);
      end
      if (bus.read) begin
        r_readdata <= w_rd_mux;
      end
    end
  end

  assign bus.readdata   = r_readdata;
  assign bus.fifo_rdreq = w_rdreq;

`ifdef FIFO_SEQ_UNDERFLOW_IRQ_EN
  assign bus.irq = r_underflow;
`else
  assign bus.irq = 1'b0;
`endif

endmodule
